dsi_lp_rx: RTL and testbench

Low-power escape-mode receiver for one DSI data lane: the receiving end of the LP signalling driven by our lane transmitter. Samples the LP_p/LP_n line pair, recognises escape-mode entry, decodes the spaced-one-hot bit stream, accepts the Low-Power Data Transmission entry command, and delivers received bytes on a valid strobe until the stop state. Sits on the peripheral-side/loopback path next to the lane, feeding the packet-level receive logic.

---
 rtl/dsi_lp_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_dsi_lp_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_lp_rx.sv
// DSI data-lane LP escape-mode receiver: synchronizes and glitch-filters LP_p/LP_n,
// decodes spaced-one-hot escape traffic and delivers LPDT bytes until the stop state.
module dsi_lp_rx #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 2048
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       lines_enable,
   input  logic       LP_p_input,
   input  logic       LP_n_input,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_active,
   output logic       rx_done,
   output logic       rx_error,
   output logic [1:0] err_code
);
   // state      | meaning
   // DISABLED   | lane off, waiting for lines_enable and LP-11
   // STOP       | idle LP-11, waiting for escape entry LP-10
   // ENT_10/00  | escape entry in progress
   // ENT_01     | escape entry, next LP-00 completes it
   // ENT_SPACE  | entry complete, first space of the command byte
   // CMD        | receiving the entry command byte
   // DATA       | LPDT, receiving data bytes
   // WAIT_STOP  | after an error, ignore the line until LP-11
   typedef enum logic [3:0] {
      S_DISABLED, S_STOP, S_ENT_10, S_ENT_00, S_ENT_01, S_ENT_SPACE, S_CMD, S_DATA, S_WAIT_STOP
   } state_t;

   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP10 = 2'b10;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP00 = 2'b00;
   localparam logic [7:0] CMD_LPDT = 8'b1110_0001;
   localparam int TW = ($clog2(TIMEOUT + 1) < 11) ? 11 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT - 1);
   localparam logic [3:0] FLT_RELOAD = 4'(FILTER_LEN - 1);

   logic [1:0] meta_q, sync_q, cand_q, acc_q, acc_prev_q;
   logic [3:0] flt_cnt_q;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         meta_q     <= LP11;
         sync_q     <= LP11;
         cand_q     <= LP11;
         acc_q      <= LP11;
         acc_prev_q <= LP11;
         flt_cnt_q  <= '0;
      end else begin
         meta_q     <= {LP_p_input, LP_n_input};
         sync_q     <= meta_q;
         acc_prev_q <= acc_q;
         // Down-counter restarts on every synchronized change; acceptance on terminal count.
         if (sync_q != cand_q) begin
            cand_q    <= sync_q;
            flt_cnt_q <= FLT_RELOAD;
            if (FLT_RELOAD == 4'd0) acc_q <= sync_q;
         end else if (flt_cnt_q != 4'd0) begin
            flt_cnt_q <= flt_cnt_q - 4'd1;
            if (flt_cnt_q == 4'd1) acc_q <= cand_q;
         end
      end
   end

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d, shifted;
   logic [1:0]    mark_q, mark_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    data_q, data_d;
   logic [1:0]    code_q, code_d, fire_code;
   logic          valid_q, valid_d, done_q, done_d, error_q, error_d, active_q;
   logic          chg, idle_st, fire_err, commit, bit_val;

   assign chg     = (acc_q != acc_prev_q);
   assign idle_st = (state_q == S_STOP) || (state_q == S_DISABLED) || (state_q == S_WAIT_STOP);
   assign shifted = {shift_q[6:0], bit_val};

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      mark_d    = mark_q;
      data_d    = data_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b0;
      fire_err  = 1'b0;
      fire_code = 2'd0;
      commit    = 1'b0;
      bit_val   = 1'b0;
      tmo_d     = (idle_st || chg) ? TMO_RELOAD : ((tmo_q != '0) ? tmo_q - 1'b1 : tmo_q);

      case (state_q)
         S_DISABLED:  if (lines_enable && acc_q == LP11) state_d = S_STOP;
         S_STOP:      if (chg && acc_q == LP10) state_d = S_ENT_10;
         S_ENT_10:    if (chg) begin
                         if (acc_q == LP00) state_d = S_ENT_00;
                         else fire_err = 1'b1;
                      end
         S_ENT_00:    if (chg) begin
                         if (acc_q == LP01) state_d = S_ENT_01;
                         else fire_err = 1'b1;
                      end
         S_ENT_01:    if (chg) begin
                         if (acc_q == LP00) begin
                            state_d   = S_ENT_SPACE;
                            bit_cnt_d = 3'd0;
                            mark_d    = LP00;
                         end else fire_err = 1'b1;
                      end
         S_ENT_SPACE, S_CMD, S_DATA: begin
            if (state_q == S_ENT_SPACE) state_d = S_CMD;
            if (chg) begin
               case (mark_q)
                  LP10: begin
                     if (acc_q == LP00) begin
                        commit  = 1'b1;
                        bit_val = 1'b1;
                     end else if (acc_q == LP11) begin
                        state_d = S_STOP;
                        mark_d  = LP00;
                        if (bit_cnt_q == 3'd0) done_d = 1'b1;
                        else begin
                           fire_err  = 1'b1;
                           fire_code = 2'd2;
                        end
                     end else fire_err = 1'b1;
                  end
                  LP01: begin
                     if (acc_q == LP00) commit = 1'b1;
                     else fire_err = 1'b1;
                  end
                  default: begin
                     if (acc_q == LP10 || acc_q == LP01) mark_d = acc_q;
                     else fire_err = 1'b1;
                  end
               endcase
            end else if (tmo_q == '0) begin
               fire_err  = 1'b1;
               fire_code = 2'd3;
            end
            if (commit) begin
               shift_d = shifted;
               mark_d  = LP00;
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
                  if (state_q == S_DATA) begin
                     valid_d = 1'b1;
                     data_d  = shifted;
                  end else if (shifted == CMD_LPDT) state_d = S_DATA;
                  else begin
                     fire_err  = 1'b1;
                     fire_code = 2'd1;
                  end
               end else bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         S_WAIT_STOP: if (acc_q == LP11) state_d = S_STOP;
         default:     state_d = S_DISABLED;
      endcase

      // Entry states can also stall on the line; they share the timeout.
      if (!chg && tmo_q == '0 && (state_q == S_ENT_10 || state_q == S_ENT_00 || state_q == S_ENT_01)) begin
         fire_err  = 1'b1;
         fire_code = 2'd3;
      end

      if (fire_err) begin
         error_d = 1'b1;
         code_d  = fire_code;
         valid_d = 1'b0;
         done_d  = 1'b0;
         data_d  = data_q;
         mark_d  = LP00;
         state_d = (acc_q == LP11) ? S_STOP : S_WAIT_STOP;
      end

      if (!lines_enable) begin
         state_d   = S_DISABLED;
         valid_d   = 1'b0;
         done_d    = 1'b0;
         error_d   = 1'b0;
         data_d    = data_q;
         code_d    = code_q;
         bit_cnt_d = 3'd0;
         shift_d   = 8'd0;
         mark_d    = LP00;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_DISABLED;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
         mark_q    <= LP00;
         tmo_q     <= TMO_RELOAD;
         data_q    <= 8'd0;
         code_q    <= 2'd0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         mark_q    <= mark_d;
         tmo_q     <= tmo_d;
         data_q    <= data_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         error_q   <= error_d;
         active_q  <= (state_q != S_STOP) && (state_q != S_DISABLED);
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign rx_done   = done_q;
   assign rx_error  = error_q;
   assign err_code  = code_q;
   assign rx_active = active_q;
endmodule

// File: tb/tb_dsi_lp_rx.sv
// Scoreboard bench for dsi_lp_rx: expected strobes are queued as line stimulus is
// driven and popped when rx_valid/rx_done/rx_error fire.
module tb_dsi_lp_rx;
   logic       clk_sys = 1'b0;
   logic       rst_n = 1'b0;
   logic       lines_enable = 1'b0;
   logic       lp_p = 1'b1;
   logic       lp_n = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_active, rx_done, rx_error;
   logic [1:0] err_code;

   localparam int TIMEOUT = 2048;
   localparam int KIND_VALID = 0;
   localparam int KIND_DONE  = 1;
   localparam int KIND_ERROR = 2;

   typedef struct {
      int kind;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk_sys = ~clk_sys;

   dsi_lp_rx #(.FILTER_LEN(4), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys      (clk_sys),
      .rst_n        (rst_n),
      .lines_enable (lines_enable),
      .LP_p_input   (lp_p),
      .LP_n_input   (lp_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_active    (rx_active),
      .rx_done      (rx_done),
      .rx_error     (rx_error),
      .err_code     (err_code)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] lp, input int cyc);
      {lp_p, lp_n} = lp;
      repeat (cyc) @(posedge clk_sys);
   endtask

   task automatic send_bit(input logic b);
      drive(b ? 2'b10 : 2'b01, 30);
      drive(2'b00, 30);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic entry();
      drive(2'b11, 30);
      drive(2'b10, 30);
      drive(2'b00, 30);
      drive(2'b01, 30);
      drive(2'b00, 30);
   endtask

   task automatic expect_ev(input int kind, input int data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic stop_clean();
      drive(2'b10, 30);
      expect_ev(KIND_DONE, 0);
      drive(2'b11, 30);
   endtask

   task automatic drain(input string tag);
      repeat (40) @(posedge clk_sys);
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   exp_t m_e;
   int   m_kind, m_data;
   always @(negedge clk_sys) begin
      if (rst_n && (rx_valid || rx_done || rx_error)) begin
         chk("one_strobe", 32'(rx_valid) + 32'(rx_done) + 32'(rx_error), 1);
         m_kind = rx_valid ? KIND_VALID : (rx_done ? KIND_DONE : KIND_ERROR);
         m_data = rx_valid ? int'(rx_data) : (rx_error ? int'(err_code) : 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 32'(m_kind * 256 + m_data), 32'hFFFF);
         end else begin
            m_e = exp_q.pop_front();
            chk("strobe_kind", 32'(m_kind), 32'(m_e.kind));
            chk("strobe_payload", 32'(m_data), 32'(m_e.data));
         end
      end
   end

   initial begin
      #200_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_active", rx_active, 0);
      chk("rst_rx_done", rx_done, 0);
      chk("rst_rx_error", rx_error, 0);
      chk("rst_err_code", err_code, 0);
      repeat (3) @(posedge clk_sys);
      rst_n = 1'b1;
      lines_enable = 1'b1;

      // Clean LPDT frame with two data bytes.
      entry();
      send_byte(8'hE1);
      chk("active_in_frame", rx_active, 1);
      expect_ev(KIND_VALID, 8'hA5);
      send_byte(8'hA5);
      expect_ev(KIND_VALID, 8'h3C);
      send_byte(8'h3C);
      stop_clean();
      drain("drain_frame");
      chk("active_after_stop", rx_active, 0);

      // Unknown command, then recovery with a fresh frame.
      entry();
      expect_ev(KIND_ERROR, 1);
      send_byte(8'h87);
      drive(2'b11, 30);
      entry();
      send_byte(8'hE1);
      expect_ev(KIND_VALID, 8'h01);
      send_byte(8'h01);
      stop_clean();
      drain("drain_bad_cmd");

      // Partial byte at stop.
      entry();
      send_byte(8'hE1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      drive(2'b10, 30);
      expect_ev(KIND_ERROR, 2);
      drive(2'b11, 30);
      drain("drain_partial");
      chk("active_partial", rx_active, 0);

      // Broken entry sequence, then a glitch inside a mark.
      drive(2'b11, 30);
      drive(2'b10, 30);
      expect_ev(KIND_ERROR, 0);
      drive(2'b01, 30);
      drive(2'b11, 30);
      drain("drain_bad_entry");
      entry();
      send_byte(8'hE1);
      expect_ev(KIND_VALID, 8'hC3);
      drive(2'b10, 14);
      drive(2'b00, 2);
      drive(2'b10, 14);
      drive(2'b00, 30);
      send_bit(1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      stop_clean();
      drain("drain_glitch");

      // Timeout with the line stuck in LP-00.
      entry();
      expect_ev(KIND_ERROR, 3);
      drive(2'b00, TIMEOUT + 100);
      chk("active_after_timeout", rx_active, 1);
      drive(2'b11, 30);
      chk("active_after_timeout_stop", rx_active, 0);
      drain("drain_timeout");

      // lines_enable dropped mid-byte: no strobes, resume only after LP-11.
      entry();
      send_byte(8'hE1);
      send_bit(1'b1);
      send_bit(1'b1);
      drive(2'b10, 15);
      lines_enable = 1'b0;
      repeat (20) @(posedge clk_sys);
      chk("active_disabled", rx_active, 0);
      drive(2'b00, 30);
      lines_enable = 1'b1;
      drive(2'b10, 30);
      drive(2'b00, 30);
      drive(2'b01, 30);
      drive(2'b00, 30);
      chk("active_no_resume", rx_active, 0);
      drain("drain_disable");

      // Reset mid-byte.
      entry();
      send_byte(8'hE1);
      send_bit(1'b0);
      send_bit(1'b1);
      drive(2'b10, 10);
      rst_n = 1'b0;
      #1;
      chk("rst2_rx_data", rx_data, 0);
      chk("rst2_rx_active", rx_active, 0);
      chk("rst2_strobes", {rx_valid, rx_done, rx_error}, 0);
      chk("rst2_err_code", err_code, 0);
      repeat (3) @(posedge clk_sys);
      rst_n = 1'b1;
      drive(2'b00, 30);
      chk("active_after_reset", rx_active, 0);
      entry();
      send_byte(8'hE1);
      expect_ev(KIND_VALID, 8'h5A);
      send_byte(8'h5A);
      stop_clean();
      drain("drain_after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
